// File: rtl/interleaver_if.sv
// rtl/interleaver_if.sv - codeword input and serial bit output handshake bundle
// The DUT takes the slave view and the producer/consumer the master view.
interface interleaver_if #(
  parameter int n = 7
);
  logic         s_valid;
  logic         s_ready;
  logic [n-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_data;
  logic         m_first;
  logic         m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_first, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_first, m_last
  );
endinterface

// File: rtl/interleaver.sv
// rtl/interleaver.sv - two-bank transmit block interleaver with column-order serial output
// Serial bit symbol_num*b + s carries codeword s, bit b.
module interleaver #(
  parameter int n          = 7,
  parameter int symbol_num = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  interleaver_if.slave     bus,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int SW = (symbol_num > 1) ? $clog2(symbol_num) : 1;
  localparam int BW = (n > 1) ? $clog2(n) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(symbol_num - 1);
  localparam logic [BW-1:0] B_LAST = BW'(n - 1);

  logic [n-1:0]  mem [2][symbol_num];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [SW-1:0] wr_cnt;
  logic [SW-1:0] s_cnt;
  logic [BW-1:0] b_cnt;
  logic          wr_en;
  logic          rd_en;
  logic          s_wrap;
  logic          frame_end;

  // All outputs decode registered state only, so no input-to-output path exists.
  assign s_wrap      = (s_cnt == S_LAST);
  assign frame_end   = s_wrap & (b_cnt == B_LAST);
  assign bus.s_ready = ~full[wr_bank];
  assign bus.m_valid = full[rd_bank];
  assign bus.m_data  = full[rd_bank] & mem[rd_bank][s_cnt][b_cnt];
  assign bus.m_first = full[rd_bank] & (s_cnt == '0) & (b_cnt == '0);
  assign bus.m_last  = full[rd_bank] & frame_end;
  assign wr_en       = bus.s_valid & ~full[wr_bank];
  assign rd_en       = full[rd_bank] & bus.m_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_cnt] <= bus.s_data;
    end
  end

  // Write and free never target the same bank, so both full-flag updates land.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      s_cnt     <= '0;
      b_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      if (wr_en) begin
        if (wr_cnt == S_LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_en) begin
        if (frame_end) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          s_cnt         <= '0;
          b_cnt         <= '0;
          frame_cnt     <= frame_cnt + 1'b1;
        end else if (s_wrap) begin
          s_cnt <= '0;
          b_cnt <= b_cnt + 1'b1;
        end else begin
          s_cnt <= s_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_interleaver.sv
// tb/tb_interleaver.sv - randomized and directed bench for interleaver against a frame-level model
module tb_interleaver;
  localparam int N     = 7;
  localparam int SYM   = 4;
  localparam int FRAME = N * SYM;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] frame_cnt;

  interleaver_if #(.n(N)) bus ();

  interleaver #(.n(N), .symbol_num(SYM), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Model: accepted codewords of the open frame, and the serial bits still owed.
  logic [N-1:0]     cw_q [$];
  bit               exp_q [$];
  int               rd_pos;
  int               frames;
  int               n_checks;
  int               n_pass;
  logic             acc;
  logic             obs_mv;
  logic             obs_sr;
  logic [CNT_W-1:0] obs_fc;
  logic             cap_on;
  int               cap_n;
  logic [FRAME-1:0] cap_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pending_frames();
    return (exp_q.size() + FRAME - 1) / FRAME;
  endfunction

  function automatic logic [FRAME-1:0] deint(input logic [FRAME-1:0] w);
    logic [FRAME-1:0] r;
    r = '0;
    for (int s = 0; s < SYM; s++)
      for (int b = 0; b < N; b++)
        r[N*s+b] = w[SYM*b+s];
    return r;
  endfunction

  task automatic check_outputs();
    check("s_ready", 32'(bus.s_ready), 32'(pending_frames() < 2));
    check("m_valid", 32'(bus.m_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
      check("m_first", 32'(bus.m_first), 32'(rd_pos == 0));
      check("m_last", 32'(bus.m_last), 32'(rd_pos == FRAME - 1));
    end else begin
      check("m_data_idle", 32'(bus.m_data), 32'(0));
      check("m_first_idle", 32'(bus.m_first), 32'(0));
      check("m_last_idle", 32'(bus.m_last), 32'(0));
    end
    check("frame_cnt", 32'(frame_cnt), 32'(frames % (1 << CNT_W)));
  endtask

  // One cycle: observe at negedge, drive inputs, and book the handshakes of the next posedge.
  task automatic step(input logic sv, input logic [N-1:0] sd, input logic mr);
    @(negedge clk);
    check_outputs();
    obs_mv = bus.m_valid;
    obs_sr = bus.s_ready;
    obs_fc = frame_cnt;
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    acc = sv & bus.s_ready;
    if (bus.m_valid && mr) begin
      if (cap_on && cap_n < FRAME) begin
        cap_w[cap_n] = bus.m_data;
        cap_n++;
      end
      void'(exp_q.pop_front());
      rd_pos = (rd_pos + 1) % FRAME;
      if (rd_pos == 0) frames++;
    end
    if (acc) begin
      cw_q.push_back(sd);
      if (cw_q.size() == SYM) begin
        for (int i = 0; i < FRAME; i++) exp_q.push_back(cw_q[i % SYM][i / SYM]);
        cw_q.delete();
      end
    end
  endtask

  task automatic send(input logic [N-1:0] cw, input logic mr);
    int t;
    t = 0;
    do begin
      step(1'b1, cw, mr);
      t++;
    end while (!acc && t < 200);
    if (!acc) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      step(1'b0, '0, 1'b1);
      t++;
    end
    check("drain_done", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cw_q.delete();
    exp_q.delete();
    rd_pos = 0;
    frames = 0;
  endtask

  task automatic cap_start();
    cap_on = 1'b1;
    cap_n  = 0;
    cap_w  = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int               sent;
    int               bits;
    int               paused;
    int               acc_at_full;
    int               bubbles;
    int               t;
    logic [CNT_W-1:0] fc0;
    logic [CNT_W-1:0] fc1;
    logic [N-1:0]     cw;
    logic [N-1:0]     cws [SYM];
    logic             mr;

    n_checks = 0;
    n_pass   = 0;
    cap_on   = 1'b0;
    cap_n    = 0;
    cap_w    = '0;
    rst      = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    do_reset();

    step(1'b0, '0, 1'b0);
    check("rst_s_ready", 32'(obs_sr), 32'(1));
    check("rst_m_valid", 32'(obs_mv), 32'(0));
    check("rst_frame_cnt", 32'(obs_fc), 32'(0));

    // Single set bit in codeword 0, bit 0.
    cap_start();
    send(7'h01, 1'b1);
    for (int i = 1; i < SYM; i++) send(7'h00, 1'b1);
    drain();
    step(1'b0, '0, 1'b0);
    check("t1_word", 32'(cap_w), 32'h0000001);
    check("t1_frame_cnt", 32'(obs_fc), 32'(1));

    // Codeword 3, bit 6 lands on serial bit 27.
    cap_start();
    for (int i = 0; i < SYM - 1; i++) send(7'h00, 1'b1);
    send(7'h40, 1'b1);
    drain();
    check("t2_word", 32'(cap_w), 32'h8000000);

    // Round trip through the inverse map.
    cap_start();
    send(7'h55, 1'b1);
    send(7'h2A, 1'b1);
    send(7'h7F, 1'b1);
    send(7'h00, 1'b1);
    drain();
    check("t3_roundtrip", 32'(deint(cap_w)), 32'({7'h00, 7'h7F, 7'h2A, 7'h55}));
    cap_on = 1'b0;

    // Twelve codewords back-to-back with a 5-cycle stall at bit 10.
    sent = 0; bits = 0; paused = 0; acc_at_full = -1;
    cw = N'($urandom);
    t = 0;
    while ((sent < 12 || exp_q.size() > 0) && t < 400) begin
      mr = !(bits == 10 && paused < 5);
      step(sent < 12, cw, mr);
      if (obs_mv && mr) bits++;
      if (obs_mv && !mr) paused++;
      if (sent < 12 && !obs_sr && acc_at_full < 0) acc_at_full = sent;
      if (acc) begin
        sent++;
        cw = N'($urandom);
      end
      t++;
    end
    check("t4_sent", 32'(sent), 32'(12));
    check("t4_paused", 32'(paused), 32'(5));
    check("t4_full_after", 32'(acc_at_full), 32'(8));
    drain();

    // Continuous flow: no bubbles and one frame per FRAME cycles.
    t = 0;
    while (exp_q.size() == 0 && t < 50) begin
      step(1'b1, N'($urandom), 1'b1);
      t++;
    end
    check("t5_start", 32'(exp_q.size() > 0), 32'(1));
    bubbles = 0;
    fc0 = '0;
    fc1 = '0;
    for (int i = 0; i <= 5 * FRAME; i++) begin
      step(1'b1, N'($urandom), 1'b1);
      if (i == 0) fc0 = obs_fc;
      if (i == 5 * FRAME) fc1 = obs_fc;
      else if (!obs_mv) bubbles++;
    end
    check("t5_bubbles", 32'(bubbles), 32'(0));
    check("t5_frames", 32'(CNT_W'(fc1 - fc0)), 32'(5));
    drain();

    // Reset with one frame mid-emission and a half-written frame pending.
    for (int i = 0; i < SYM; i++) send(N'($urandom), 1'b0);
    send(N'($urandom), 1'b0);
    send(N'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b0, '0, 1'b0);
    check("t6_s_ready", 32'(obs_sr), 32'(1));
    check("t6_m_valid", 32'(obs_mv), 32'(0));
    check("t6_frame_cnt", 32'(obs_fc), 32'(0));
    cap_start();
    for (int i = 0; i < SYM; i++) begin
      cws[i] = N'($urandom);
      send(cws[i], 1'b1);
    end
    drain();
    check("t6_roundtrip", 32'(deint(cap_w)), 32'({cws[3], cws[2], cws[1], cws[0]}));
    cap_on = 1'b0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, N'($urandom), $urandom_range(0, 9) < 6);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
